// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: VGA scan-out has absolute priority, blur fills idle slots.
// Registered RAM controls; read data is routed back through a fixed-latency tag pipe.
module fb_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 76800,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              blr_req,
  input  logic              blr_we,
  input  logic [ADDR_W-1:0] blr_addr,
  input  logic [DATA_W-1:0] blr_wdata,
  output logic              blr_gnt,
  output logic              blr_rvalid,
  output logic [DATA_W-1:0] blr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starve,
  output logic              err_oob
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic              w_blr_slot;
  logic              w_slot;
  logic              w_oob;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_ret;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [RD_LAT:0]   r_tv;
  logic [RD_LAT:0]   r_to;
  logic [RD_LAT:0]   r_too;
  logic              r_vga_rvalid;
  logic              r_blr_rvalid;
  logic [DATA_W-1:0] r_vga_rdata;
  logic [DATA_W-1:0] r_blr_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err_oob;

  assign w_blr_slot = blr_req & ~vga_req;
  assign w_slot     = vga_req | blr_req;
  assign w_addr     = vga_req ? vga_addr : blr_addr;
  assign w_oob      = {1'b0, w_addr} >= LIMIT;
  assign w_rd       = vga_req | (blr_req & ~blr_we);
  assign w_wr       = w_blr_slot & blr_we;

  assign blr_gnt    = w_blr_slot;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign vga_rvalid = r_vga_rvalid;
  assign blr_rvalid = r_blr_rvalid;
  assign vga_rdata  = r_vga_rdata;
  assign blr_rdata  = r_blr_rdata;
  assign starve     = (r_cnt == CNT_MAX);
  assign err_oob    = r_err_oob;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= w_slot & ~w_oob;
      r_mem_we <= w_wr & ~w_oob;
      if (w_slot) begin
        r_mem_addr  <= w_addr;
        r_mem_wdata <= blr_wdata;
      end
    end
  end

  // Tag stage RD_LAT lines up with mem_rdata of the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tv  <= '0;
      r_to  <= '0;
      r_too <= '0;
    end else begin
      r_tv  <= {r_tv[RD_LAT-1:0], w_rd};
      r_to  <= {r_to[RD_LAT-1:0], ~vga_req};
      r_too <= {r_too[RD_LAT-1:0], w_oob};
    end
  end

  assign w_ret = r_too[RD_LAT] ? '0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vga_rvalid <= 1'b0;
      r_blr_rvalid <= 1'b0;
      r_vga_rdata  <= '0;
      r_blr_rdata  <= '0;
    end else begin
      r_vga_rvalid <= r_tv[RD_LAT] & ~r_to[RD_LAT];
      r_blr_rvalid <= r_tv[RD_LAT] & r_to[RD_LAT];
      if (r_tv[RD_LAT] & ~r_to[RD_LAT]) r_vga_rdata <= w_ret;
      if (r_tv[RD_LAT] & r_to[RD_LAT])  r_blr_rdata <= w_ret;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_err_oob <= 1'b0;
    end else begin
      if (blr_req & vga_req) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_slot & w_oob) r_err_oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed and random checks of fb_port_arbiter against a behavioural RAM
// and an independent grant-order memory model.
module tb_fb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        vga_req;
  logic [16:0] vga_addr;
  logic        vga_rvalid;
  logic [15:0] vga_rdata;
  logic        blr_req;
  logic        blr_we;
  logic [16:0] blr_addr;
  logic [15:0] blr_wdata;
  logic        blr_gnt;
  logic        blr_rvalid;
  logic [15:0] blr_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        starve;
  logic        err_oob;

  int errors = 0;
  int checks = 0;

  logic [15:0] ram   [0:131071];
  logic [15:0] ref_m [0:131071];

  fb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .blr_req(blr_req), .blr_we(blr_we),
    .blr_addr(blr_addr), .blr_wdata(blr_wdata),
    .blr_gnt(blr_gnt), .blr_rvalid(blr_rvalid),
    .blr_rdata(blr_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .starve(starve), .err_oob(err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    vga_req   = 1'b0;
    vga_addr  = '0;
    blr_req   = 1'b0;
    blr_we    = 1'b0;
    blr_addr  = '0;
    blr_wdata = '0;
  endtask

  task automatic test_reset;
    idle();
    rst = 1'b1;
    blr_req = 1'b1;
    tick();
    tick();
    checks++;
    if ({mem_en, mem_we, vga_rvalid, blr_rvalid, starve, err_oob} !== 6'b0)
      begin errors++; $display("FAIL reset_flags: got %b want 000000",
        {mem_en, mem_we, vga_rvalid, blr_rvalid, starve, err_oob}); end
    checks++;
    if ({mem_addr, mem_wdata, vga_rdata, blr_rdata} !== 65'b0)
      begin errors++; $display("FAIL reset_data: got %h want 0",
        {mem_addr, mem_wdata, vga_rdata, blr_rdata}); end
    checks++;
    if (blr_gnt !== 1'b1)
      begin errors++; $display("FAIL reset_gnt_hi: got %b want 1", blr_gnt); end
    vga_req = 1'b1;
    #1;
    checks++;
    if (blr_gnt !== 1'b0)
      begin errors++; $display("FAIL reset_gnt_lo: got %b want 0", blr_gnt); end
    rst = 1'b0;
    idle();
    tick();
    tick();
  endtask

  task automatic test_priority;
    logic [15:0] ev;
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c < 5) begin
        blr_req  = 1'b1;
        blr_addr = 17'd10;
      end
      if (c < 4) begin
        vga_req  = 1'b1;
        vga_addr = 17'(c);
      end
      #1;
      if (c < 5) begin
        checks++;
        if (blr_gnt !== (c == 4))
          begin errors++; $display("FAIL prio_gnt c%0d: got %b want %b", c, blr_gnt, c == 4); end
      end
      checks++;
      if (vga_rvalid !== (c >= 3 && c <= 6))
        begin errors++; $display("FAIL prio_vrv c%0d: got %b", c, vga_rvalid); end
      if (c >= 3 && c <= 6) begin
        ev = 16'(c - 3) ^ 16'hA5A5;
        checks++;
        if (vga_rdata !== ev)
          begin errors++; $display("FAIL prio_vdata c%0d: got %h want %h", c, vga_rdata, ev); end
      end
      checks++;
      if (blr_rvalid !== (c == 7))
        begin errors++; $display("FAIL prio_brv c%0d: got %b", c, blr_rvalid); end
      if (c == 7) begin
        checks++;
        if (blr_rdata !== 16'hA5AF)
          begin errors++; $display("FAIL prio_bdata: got %h want a5af", blr_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_write_read;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) begin
        blr_req   = 1'b1;
        blr_we    = 1'b1;
        blr_addr  = 17'd500;
        blr_wdata = 16'h1234;
      end
      if (c == 1) begin
        vga_req  = 1'b1;
        vga_addr = 17'd500;
      end
      #1;
      if (c < 4) begin
        checks++;
        if (mem_we !== (c == 1))
          begin errors++; $display("FAIL wr_we c%0d: got %b want %b", c, mem_we, c == 1); end
      end
      if (c >= 3) begin
        checks++;
        if (vga_rvalid !== (c == 4))
          begin errors++; $display("FAIL wr_vrv c%0d: got %b", c, vga_rvalid); end
      end
      if (c == 4) begin
        checks++;
        if (vga_rdata !== 16'h1234)
          begin errors++; $display("FAIL wr_data: got %h want 1234", vga_rdata); end
      end
      tick();
    end
    ref_m[500] = 16'h1234;
  endtask

  task automatic test_oob;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) begin
        blr_req  = 1'b1;
        blr_addr = 17'd76800;
      end
      if (c == 1) begin
        blr_req   = 1'b1;
        blr_we    = 1'b1;
        blr_addr  = 17'd90000;
        blr_wdata = 16'hBEEF;
      end
      #1;
      if (c < 2) begin
        checks++;
        if (blr_gnt !== 1'b1)
          begin errors++; $display("FAIL oob_gnt c%0d: got %b want 1", c, blr_gnt); end
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if (mem_en !== 1'b0)
          begin errors++; $display("FAIL oob_en c%0d: got %b want 0", c, mem_en); end
      end
      checks++;
      if (err_oob !== (c >= 1))
        begin errors++; $display("FAIL oob_err c%0d: got %b want %b", c, err_oob, c >= 1); end
      if (c >= 2) begin
        checks++;
        if (blr_rvalid !== (c == 3))
          begin errors++; $display("FAIL oob_rv c%0d: got %b", c, blr_rvalid); end
      end
      if (c == 3) begin
        checks++;
        if (blr_rdata !== 16'h0)
          begin errors++; $display("FAIL oob_data: got %h want 0000", blr_rdata); end
      end
      tick();
    end
    checks++;
    if (ram[90000] !== ref_m[90000])
      begin errors++; $display("FAIL oob_ram: got %h want %h", ram[90000], ref_m[90000]); end
  endtask

  task automatic test_starve;
    for (int c = 0; c < 302; c++) begin
      idle();
      if (c < 301) begin
        blr_req  = 1'b1;
        blr_addr = 17'd5;
      end
      if (c < 300) vga_req = 1'b1;
      #1;
      if (c == 0 || c == 254) begin
        checks++;
        if (starve !== 1'b0)
          begin errors++; $display("FAIL starve_lo c%0d: got %b want 0", c, starve); end
      end
      if (c == 255 || c == 299 || c == 300) begin
        checks++;
        if (starve !== 1'b1)
          begin errors++; $display("FAIL starve_hi c%0d: got %b want 1", c, starve); end
      end
      if (c == 300) begin
        checks++;
        if (blr_gnt !== 1'b1)
          begin errors++; $display("FAIL starve_gnt: got %b want 1", blr_gnt); end
      end
      if (c == 301) begin
        checks++;
        if (starve !== 1'b0)
          begin errors++; $display("FAIL starve_clr: got %b want 0", starve); end
      end
      tick();
    end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_rst_flight;
    for (int c = 0; c < 9; c++) begin
      idle();
      rst = (c == 2);
      if (c < 2) begin
        vga_req  = 1'b1;
        vga_addr = 17'(c + 1);
      end
      #1;
      if (c == 3) begin
        checks++;
        if ({mem_en, mem_we, starve, err_oob, blr_gnt} !== 5'b0)
          begin errors++; $display("FAIL rstf_flags: got %b want 00000",
            {mem_en, mem_we, starve, err_oob, blr_gnt}); end
        checks++;
        if ({mem_addr, mem_wdata, vga_rdata, blr_rdata} !== 65'b0)
          begin errors++; $display("FAIL rstf_data: got %h want 0",
            {mem_addr, mem_wdata, vga_rdata, blr_rdata}); end
      end
      if (c >= 3) begin
        checks++;
        if ({vga_rvalid, blr_rvalid} !== 2'b00)
          begin errors++; $display("FAIL rstf_rv c%0d: got %b want 00", c, {vga_rvalid, blr_rvalid}); end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  function automatic logic [16:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 17'($urandom_range(76800, 131071));
    if (r < 8) return 17'($urandom_range(0, 31));
    return 17'($urandom_range(0, 76799));
  endfunction

  task automatic test_random;
    int          q_cyc [$];
    bit          q_own [$];
    logic [15:0] q_dat [$];
    bit          pend;
    bit          egnt;
    bit          hit;
    int          rerr;
    logic [16:0] a;
    pend = 1'b0;
    rerr = 0;
    idle();
    for (int c = 0; c < 10000; c++) begin
      vga_req  = ($urandom_range(0, 2) == 0);
      vga_addr = rand_addr();
      if (!pend) begin
        blr_req   = $urandom_range(0, 1) == 1;
        blr_we    = $urandom_range(0, 1) == 1;
        blr_addr  = rand_addr();
        blr_wdata = 16'($urandom);
      end
      #1;
      egnt = blr_req && !vga_req;
      checks++;
      if (blr_gnt !== egnt) begin
        errors++;
        if (rerr++ < 10) $display("FAIL rnd_gnt c%0d: got %b want %b", c, blr_gnt, egnt);
      end
      if (vga_req) begin
        a = vga_addr;
        q_cyc.push_back(c + 3);
        q_own.push_back(1'b0);
        q_dat.push_back(a >= 17'd76800 ? 16'h0 : ref_m[a]);
      end else if (blr_req) begin
        a = blr_addr;
        if (blr_we) begin
          if (a < 17'd76800) ref_m[a] = blr_wdata;
        end else begin
          q_cyc.push_back(c + 3);
          q_own.push_back(1'b1);
          q_dat.push_back(a >= 17'd76800 ? 16'h0 : ref_m[a]);
        end
      end
      pend = blr_req && !egnt;
      hit = (q_cyc.size() > 0) && (q_cyc[0] == c);
      checks++;
      if (vga_rvalid !== (hit && !q_own[0]) || blr_rvalid !== (hit && q_own[0])) begin
        errors++;
        if (rerr++ < 10) $display("FAIL rnd_rv c%0d: got v%b b%b want hit%b own%b",
          c, vga_rvalid, blr_rvalid, hit, hit ? q_own[0] : 1'b0);
      end else if (hit) begin
        checks++;
        if ((q_own[0] ? blr_rdata : vga_rdata) !== q_dat[0]) begin
          errors++;
          if (rerr++ < 10) $display("FAIL rnd_data c%0d: got %h want %h",
            c, q_own[0] ? blr_rdata : vga_rdata, q_dat[0]);
        end
      end
      checks++;
      if (vga_rvalid && blr_rvalid) begin
        errors++;
        if (rerr++ < 10) $display("FAIL rnd_both c%0d: both rvalid high", c);
      end
      if (hit) begin
        void'(q_cyc.pop_front());
        void'(q_own.pop_front());
        void'(q_dat.pop_front());
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) begin
      ram[i]   = 16'(i) ^ 16'hA5A5;
      ref_m[i] = 16'(i) ^ 16'hA5A5;
    end
    rst = 1'b1;
    idle();
    test_reset();
    test_priority();
    test_write_read();
    test_oob();
    test_starve();
    test_rst_flight();
    tick();
    tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
